dco_loop_filter: RTL and testbench



---
 rtl/dlf_pkg.sv | 37 +++
 rtl/dlf_lock_fsm.sv | 106 ++++++++++
 rtl/dco_loop_filter.sv | 126 ++++++++++++
 tb/tb_dco_loop_filter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dlf_pkg.sv
// dlf_pkg: shared types and defaults for the DCO loop filter.
//   dlf_state_e  : lock state machine encoding (ACQ=0, TRACK=1, LOCKED=2)
//   DLF_*        : default gains, thresholds and widths
//   sclamp()     : signed clamp of an accumulator-width value
package dlf_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } dlf_state_e;

  // Accumulator width is fixed here so that sclamp() and the datapath agree.
  localparam int DLF_ACC_W         = 32;
  localparam int DLF_ERR_RANGE     = 4000;
  localparam int DLF_CODE_W        = 10;
  localparam int DLF_INIT_CODE     = 512;
  localparam int DLF_FRAC_W        = 8;
  localparam int DLF_KP_SHIFT      = 2;
  localparam int DLF_KI_SHIFT      = 6;
  localparam int DLF_ACQ_BOOST     = 2;
  localparam int DLF_LOCK_THRESH   = 8;
  localparam int DLF_UNLOCK_THRESH = 64;
  localparam int DLF_LOCK_CYCLES   = 32;
  localparam int DLF_SLIP_CYCLES   = 4;

  function automatic logic signed [DLF_ACC_W-1:0] sclamp(
    input logic signed [DLF_ACC_W-1:0] val,
    input logic signed [DLF_ACC_W-1:0] lo,
    input logic signed [DLF_ACC_W-1:0] hi
  );
    if (val < lo)      return lo;
    else if (val > hi) return hi;
    else               return val;
  endfunction

endpackage

// File: rtl/dlf_lock_fsm.sv
// dlf_lock_fsm: acquisition / track / lock state machine.
// Ports:
//   fbclk    in  update clock
//   resetn   in  asynchronous active-low reset
//   hold     in  freezes state and all counters
//   err_mag  in  |err_q|, magnitude of the registered phase error
//   state    out current state (registered)
//   locked   out high only in LOCKED (registered with state)
// Counters restart on every state change. The slip rule (|err| at full range
// for SLIP_CYCLES cycles) overrides every other transition.
module dlf_lock_fsm
  import dlf_pkg::*;
#(
  parameter int ERR_RANGE     = DLF_ERR_RANGE,
  parameter int LOCK_THRESH   = DLF_LOCK_THRESH,
  parameter int UNLOCK_THRESH = DLF_UNLOCK_THRESH,
  parameter int LOCK_CYCLES   = DLF_LOCK_CYCLES,
  parameter int SLIP_CYCLES   = DLF_SLIP_CYCLES
) (
  input  logic                 fbclk,
  input  logic                 resetn,
  input  logic                 hold,
  input  logic [DLF_ACC_W-1:0] err_mag,
  output dlf_state_e           state,
  output logic                 locked
);

  localparam int ACQ_CYCLES = 2;
  localparam int AW = $clog2(ACQ_CYCLES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int SW = $clog2(SLIP_CYCLES + 1);

  logic [AW-1:0] acq_cnt, acq_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic [SW-1:0] slip_cnt, slip_nxt;
  logic          acq_hit, lock_hit, slip_hit, unlock_hit;

  always_comb begin
    acq_nxt    = (err_mag <= UNLOCK_THRESH) ? acq_cnt + 1'b1 : '0;
    lock_nxt   = (err_mag <= LOCK_THRESH) ? lock_cnt + 1'b1 : '0;
    slip_nxt   = (err_mag == ERR_RANGE) ? slip_cnt + 1'b1 : '0;
    acq_hit    = (acq_nxt == AW'(ACQ_CYCLES));
    lock_hit   = (lock_nxt == LW'(LOCK_CYCLES));
    slip_hit   = (slip_nxt == SW'(SLIP_CYCLES));
    unlock_hit = (err_mag > UNLOCK_THRESH);
  end

  always_ff @(posedge fbclk or negedge resetn) begin
    if (!resetn) begin
      state    <= ACQ;
      locked   <= 1'b0;
      acq_cnt  <= '0;
      lock_cnt <= '0;
      slip_cnt <= '0;
    end else if (!hold) begin
      if (slip_hit) begin
        state    <= ACQ;
        locked   <= 1'b0;
        acq_cnt  <= '0;
        lock_cnt <= '0;
        slip_cnt <= '0;
      end else begin
        case (state)
          ACQ: begin
            if (acq_hit) begin
              state    <= TRACK;
              acq_cnt  <= '0;
              slip_cnt <= '0;
            end else begin
              acq_cnt  <= acq_nxt;
              slip_cnt <= slip_nxt;
            end
          end
          TRACK: begin
            if (lock_hit) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              lock_cnt <= '0;
              slip_cnt <= '0;
            end else begin
              lock_cnt <= lock_nxt;
              slip_cnt <= slip_nxt;
            end
          end
          LOCKED: begin
            if (unlock_hit) begin
              state    <= TRACK;
              locked   <= 1'b0;
              slip_cnt <= '0;
            end else begin
              slip_cnt <= slip_nxt;
            end
          end
          default: begin
            state    <= ACQ;
            locked   <= 1'b0;
            acq_cnt  <= '0;
            lock_cnt <= '0;
            slip_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/dco_loop_filter.sv
// dco_loop_filter: digital PI loop filter driving the DCO tuning code.
// Ports:
//   fbclk      in  divided feedback clock (update clock)
//   resetn     in  asynchronous active-low reset
//   phase_err  in  signed TDC phase error; positive => raise the code
//   hold       in  freeze integrator and lock FSM, proportional path live
//   dco_code   out registered DCO tuning code
//   locked     out high only in LOCKED
//   state      out lock FSM state (ACQ=0, TRACK=1, LOCKED=2)
// Pipeline: phase_err is clamped into err_q on one edge; err_q drives the
// integrator, dco_code and the FSM on the next edge.
// Optional build macro DLF_SIGMA_DELTA_EN: first-order error-feedback
// modulator on the fractional part of the sum instead of plain truncation.
module dco_loop_filter
  import dlf_pkg::*;
#(
  parameter int ERR_RANGE     = DLF_ERR_RANGE,
  parameter int CODE_W        = DLF_CODE_W,
  parameter int INIT_CODE     = DLF_INIT_CODE,
  parameter int FRAC_W        = DLF_FRAC_W,
  parameter int KP_SHIFT      = DLF_KP_SHIFT,
  parameter int KI_SHIFT      = DLF_KI_SHIFT,
  parameter int ACQ_BOOST     = DLF_ACQ_BOOST,
  parameter int LOCK_THRESH   = DLF_LOCK_THRESH,
  parameter int UNLOCK_THRESH = DLF_UNLOCK_THRESH,
  parameter int LOCK_CYCLES   = DLF_LOCK_CYCLES,
  parameter int SLIP_CYCLES   = DLF_SLIP_CYCLES
) (
  input  logic                        fbclk,
  input  logic                        resetn,
  input  logic signed [DLF_ACC_W-1:0] phase_err,
  input  logic                        hold,
  output logic        [CODE_W-1:0]    dco_code,
  output logic                        locked,
  output logic        [1:0]           state
);

  localparam int ACC_W = DLF_ACC_W;

  localparam logic signed [ACC_W-1:0] ERR_MAX   = ACC_W'(ERR_RANGE);
  localparam logic signed [ACC_W-1:0] ERR_MIN   = -ERR_MAX;
  localparam logic signed [ACC_W-1:0] BASE      = ACC_W'(INIT_CODE * (2 ** FRAC_W));
  localparam logic signed [ACC_W-1:0] INTEG_MIN = -BASE;
  localparam logic signed [ACC_W-1:0] INTEG_MAX =
    ACC_W'((2 ** CODE_W - 1 - INIT_CODE) * (2 ** FRAC_W));
  localparam logic signed [ACC_W-1:0] CODE_MAX  = ACC_W'(2 ** CODE_W - 1);

  // Boosted (smaller) shifts in ACQ, floored at zero.
  localparam int KP_ACQ = (KP_SHIFT > ACQ_BOOST) ? KP_SHIFT - ACQ_BOOST : 0;
  localparam int KI_ACQ = (KI_SHIFT > ACQ_BOOST) ? KI_SHIFT - ACQ_BOOST : 0;

  logic signed [ACC_W-1:0] err_q;
  logic signed [ACC_W-1:0] integ;
  logic        [ACC_W-1:0] err_mag;
  dlf_state_e              fsm_state;

  logic signed [ACC_W-1:0] scaled, prop, integ_add, integ_nxt, sum, code_full;
  logic        [CODE_W-1:0] code_nxt;
  int                       kp, ki;

`ifdef DLF_SIGMA_DELTA_EN
  logic        [FRAC_W-1:0] resid, resid_nxt;
  logic signed [ACC_W-1:0]  sum_sd;
  logic                     sat;
`endif

  assign err_mag = err_q[ACC_W-1] ? ACC_W'(-err_q) : ACC_W'(err_q);
  assign state   = fsm_state;

  always_comb begin
    kp        = (fsm_state == ACQ) ? KP_ACQ : KP_SHIFT;
    ki        = (fsm_state == ACQ) ? KI_ACQ : KI_SHIFT;
    scaled    = err_q <<< FRAC_W;
    prop      = scaled >>> kp;
    integ_add = sclamp(integ + (scaled >>> ki), INTEG_MIN, INTEG_MAX);
    integ_nxt = hold ? integ : integ_add;
    // The sum uses the integrator value being written on this same edge.
    sum       = BASE + integ_nxt + prop;
`ifdef DLF_SIGMA_DELTA_EN
    sum_sd    = sum + ACC_W'(resid);
    code_full = sum_sd >>> FRAC_W;
    sat       = (code_full < 0) || (code_full > CODE_MAX);
    resid_nxt = sat ? '0 : sum_sd[FRAC_W-1:0];
`else
    code_full = sum >>> FRAC_W;
`endif
    if (code_full < 0)             code_nxt = '0;
    else if (code_full > CODE_MAX) code_nxt = '1;
    else                           code_nxt = code_full[CODE_W-1:0];
  end

  always_ff @(posedge fbclk or negedge resetn) begin
    if (!resetn) begin
      err_q    <= '0;
      integ    <= '0;
      dco_code <= CODE_W'(INIT_CODE);
    end else begin
      err_q    <= sclamp(phase_err, ERR_MIN, ERR_MAX);
      integ    <= integ_nxt;
      dco_code <= code_nxt;
    end
  end

`ifdef DLF_SIGMA_DELTA_EN
  always_ff @(posedge fbclk or negedge resetn) begin
    if (!resetn) resid <= '0;
    else         resid <= resid_nxt;
  end
`endif

  dlf_lock_fsm #(
    .ERR_RANGE     (ERR_RANGE),
    .LOCK_THRESH   (LOCK_THRESH),
    .UNLOCK_THRESH (UNLOCK_THRESH),
    .LOCK_CYCLES   (LOCK_CYCLES),
    .SLIP_CYCLES   (SLIP_CYCLES)
  ) u_lock_fsm (
    .fbclk   (fbclk),
    .resetn  (resetn),
    .hold    (hold),
    .err_mag (err_mag),
    .state   (fsm_state),
    .locked  (locked)
  );

endmodule

// File: tb/tb_dco_loop_filter.sv
// tb_dco_loop_filter: directed checks of dco_loop_filter with hand-computed
// expected codes, states and lock flags.
module tb_dco_loop_filter;

  logic               fbclk = 1'b0;
  logic               resetn = 1'b0;
  logic signed [31:0] phase_err = '0;
  logic               hold = 1'b0;
  logic [9:0]         dco_code;
  logic               locked;
  logic [1:0]         state;

  int n_tests = 0;
  int n_fail  = 0;

  dco_loop_filter dut (
    .fbclk     (fbclk),
    .resetn    (resetn),
    .phase_err (phase_err),
    .hold      (hold),
    .dco_code  (dco_code),
    .locked    (locked),
    .state     (state)
  );

  // clock / reset
  always #5 fbclk = ~fbclk;

  task automatic tick();
    @(posedge fbclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    hold      = 1'b0;
    phase_err = '0;
    ticks(2);
    resetn = 1'b1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];

  initial begin
    // ---------------- zero error after reset, lock, loss of lock
    do_reset();
    check("rst_code", 32'(dco_code), 32'd512);
    check("rst_state", 32'(state), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    tick();                                   // edge 1
    check("acq_e1", 32'(state), 32'd0);
    tick();                                   // edge 2
    check("track_e2", 32'(state), 32'd1);
    check("code_e2", 32'(dco_code), 32'd512);
    ticks(31);                                // edge 33
    check("prelock_e33", 32'(locked), 32'd0);
    tick();                                   // edge 34
    check("lock_e34", 32'(locked), 32'd1);
    check("lock_state", 32'(state), 32'd2);
    check("lock_code", 32'(dco_code), 32'd512);

    phase_err = -32'sd100;
    tick();                                   // edge 35: -100 sampled
    check("still_locked", 32'(locked), 32'd1);
    phase_err = -32'sd4000;
    tick();                                   // edge 36: -100 evaluated
    check("unlock_state", 32'(state), 32'd1);
    check("unlock_locked", 32'(locked), 32'd0);
    check("unlock_code", 32'(dco_code), 32'd485);
    tick();                                   // edge 37
    check("neg_floor", 32'(dco_code), 32'd0);
    ticks(2);                                 // edge 39
    check("pre_slip", 32'(state), 32'd1);
    phase_err = '0;
    tick();                                   // edge 40: 4th -4000 evaluated
    check("slip_acq", 32'(state), 32'd0);
    check("slip_code", 32'(dco_code), 32'd0);
    tick();                                   // edge 41: integ = -64400
    check("recover_code", 32'(dco_code), 32'd260);
    check("recover_state", 32'(state), 32'd0);
    tick();                                   // edge 42
    check("recover_track", 32'(state), 32'd1);

    // ---------------- single pulse in TRACK, then hold and mid-cycle reset
    do_reset();
    ticks(2);
    phase_err = 32'sd64;
    tick();                                   // edge 3: pulse sampled
    phase_err = '0;
    check("pulse_lat", 32'(dco_code), 32'd512);
    tick();
    check("pulse_peak", 32'(dco_code), 32'd529);
    tick();
    check("pulse_settle", 32'(dco_code), 32'd513);
    tick();
    check("pulse_steady", 32'(dco_code), 32'd513);

    hold      = 1'b1;
    phase_err = 32'sd64;
    tick();
    check("hold_lat", 32'(dco_code), 32'd513);
    tick();
    check("hold_prop", 32'(dco_code), 32'd529);
    check("hold_integ", 32'(dut.integ), 32'd256);
    tick();
    check("hold_prop2", 32'(dco_code), 32'd529);
    check("hold_state", 32'(state), 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    check("midrst_code", 32'(dco_code), 32'd512);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);

    // ---------------- saturated error
    do_reset();
    phase_err = 32'sd5000;
    tick();                                   // edge 1
    check("sat_lat", 32'(dco_code), 32'd512);
    phase_err = '0;
    tick();                                   // edge 2: clamped 4000, ACQ gains
    check("sat_pin", 32'(dco_code), 32'd1023);
    check("sat_acq", 32'(state), 32'd0);
    tick();                                   // edge 3: integ one step only
    check("sat_integ_step", 32'(dco_code), 32'd762);

    do_reset();
    phase_err = 32'sd5000;
    ticks(6);
    check("windup_integ", 32'(dut.integ), 32'd130816);
    check("windup_code", 32'(dco_code), 32'd1023);
    check("windup_state", 32'(state), 32'd0);
    phase_err = '0;
    ticks(2);
    check("windup_hold_code", 32'(dco_code), 32'd1023);

    // ---------------- fractional integrator 0x80
    do_reset();
    ticks(2);
    phase_err = 32'sd32;
    tick();
    phase_err = '0;
    tick();                                   // prop +8, integ +0x80
    check("frac_peak", 32'(dco_code), 32'd520);
    for (int i = 0; i < 4; i++) begin
`ifdef DLF_SIGMA_DELTA_EN
      exp_q.push_back((i % 2 == 0) ? 32'd513 : 32'd512);
`else
      exp_q.push_back(32'd512);
`endif
    end
    while (exp_q.size() > 0) begin
      tick();
      check("frac_seq", 32'(dco_code), exp_q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
